cnt_burst_arb: RTL
==================

# cnt_burst_arb

Round-robin scheduler that shares one 2-bit up-counter datapath among four requesters. Each requester asks for a burst of N counting cycles; the block grants one requester at a time and clears the shared counter. It then drives the counter's enable for exactly N cycles and pulses a per-requester done. It sits between the requesting control blocks and the counter's `en`/clear inputs.

## Interface
- `LENW`, 4, width of each burst-length field; max burst = 2^LENW-1 cycles.
- `clk`  in  1  rising-edge clock, sole clock domain.
- `res`  in  1  synchronous, active-high reset.
- `req`  in  4  request, one bit per requester; held high until `done` for that requester.
- `len`  in  4*LENW  packed burst lengths; requester i uses `len[i*LENW +: LENW]`.
- `gnt`  out  4  one-hot grant; all-zero when idle.
- `gid`  out  2  index of the granted requester; 0 when idle.
- `busy`  out  1  high whenever not in IDLE.
- `cnt_clr`  out  1  one-cycle clear to the shared counter, value 2'b00.
- `cnt_en`  out  1  count enable to the shared counter.
- `done`  out  4  one-cycle pulse to the requester whose burst completed.

## Operation
- FSM states: IDLE, CLR, RUN, DONE.
- IDLE:
  - If any `req` bit is high, select the winner round-robin: search from pointer `ptr` upward, modulo 4.
  - Latch the winner's `len` into the internal down-counter `rem` (LENW bits).
  - Latch the winner's index into `gid`; go to CLR.
- CLR:
  - `gnt[gid]=1`, `cnt_clr=1`, `cnt_en=0`.
  - If `rem==0`, go to DONE; else go to RUN.
- RUN:
  - `gnt[gid]=1`, `cnt_en=1`.
  - Each cycle `rem` decrements by 1. When `rem==1` (last enable cycle), go to DONE.
- DONE:
  - `gnt[gid]=1`, `done[gid]=1`, `cnt_en=0`.
  - `ptr` becomes `gid+1` (mod 4, 2-bit wrap 3->0); go to IDLE.
- Abort: if `req[gid]` is low in CLR or RUN:
  - Go to IDLE next cycle; `cnt_en` drops that edge.
  - No `done` pulse; `ptr` still advances to `gid+1`.
- Length is sampled once, at grant. Later changes to `len` do not affect the current burst.
- Other requesters raising or dropping `req` during a burst have no effect until IDLE.
- `len` of 0 is legal: the counter is cleared, zero enable cycles follow, and `done` still pulses.
- A requester holding `req` high across its own `done` is eligible again. With `ptr` advanced, it wins only if no other requester is pending.
- `cnt_en` and `cnt_clr` are never high in the same cycle.
- `gnt` is one-hot or zero at all times.

## Timing
- All outputs are registered or decoded from registered state only; there are no combinational paths from `req`/`len` to outputs.
- Reset (`res` high at an edge):
  - State=IDLE, `ptr`=0, `rem`=0.
  - `gnt`=0, `gid`=0, `busy`=0, `cnt_clr`=0, `cnt_en`=0, `done`=0.
  - Reset during any state aborts the burst with no `done` pulse.
- Burst sequence, with `req` first high at edge t while IDLE:
  - CLR in cycle t+1.
  - `cnt_en` high in cycles t+2 .. t+1+N.
  - `done` in cycle t+2+N.
  - Next grant possible at CLR in cycle t+4+N (IDLE occupies t+3+N).
- Total occupancy per burst: N+3 cycles, including the IDLE arbitration cycle. With N=0 the occupancy is 3 cycles.
- Shared counter value after a completed burst: N mod 4, since the counter wraps 3->0.

## Test plan
- Reset then single requester:
  - Stimulus: `req`=4'b0010, `len[1]`=3.
  - Required response: `gnt`=4'b0010; `cnt_clr` for 1 cycle; `cnt_en` for 3 cycles; `done`=4'b0010 for 1 cycle; counter reads 2'b11; `busy` low afterwards.
- All four requesting continuously, each `len`=2:
  - Required response: grant order 0,1,2,3,0; each burst is 5 cycles; no `gnt` overlap.
- Zero-length burst:
  - Stimulus: `req[2]` with `len[2]`=0.
  - Required response: `cnt_clr` pulse; no `cnt_en`; `done[2]` one cycle after CLR.
- Wrap and maximum length:
  - Stimulus: `len[3]`=15.
  - Required response: exactly 15 `cnt_en` cycles; counter ends at 2'b11; `ptr` wraps so requester 0 wins next over requester 3.
- Abort:
  - Stimulus: `len[0]`=8; drop `req[0]` after the 3rd `cnt_en` cycle.
  - Required response: `cnt_en` low on the next cycle; no `done`; the next pending requester (1) is granted next.
- Mid-burst reset:
  - Stimulus: assert `res` for 1 cycle during RUN.
  - Required response: all outputs 0 on the following cycle; the pointer restart favours requester 0.

Source files
------------

// File: rtl/cnt_burst_arb_if.sv
// Request/grant bundle between the requesting control blocks and the burst arbiter,
// plus the arbiter's controls towards the shared 2-bit counter.
interface cnt_burst_arb_if #(
    parameter int unsigned LENW = 4
);
    logic [3:0]        req;
    logic [4*LENW-1:0] len;
    logic [3:0]        gnt;
    logic [1:0]        gid;
    logic              busy;
    logic              cnt_clr;
    logic              cnt_en;
    logic [3:0]        done;

    modport master (
        output req, len,
        input  gnt, gid, busy, cnt_clr, cnt_en, done
    );

    modport slave (
        input  req, len,
        output gnt, gid, busy, cnt_clr, cnt_en, done
    );
endinterface

// File: rtl/cnt_burst_arb.sv
// Round-robin burst scheduler: grants one of four requesters, clears the shared counter,
// enables it for the latched burst length and pulses done for the winner.
module cnt_burst_arb #(
    parameter int unsigned LENW = 4
) (
    input logic             clk,
    input logic             res,
    cnt_burst_arb_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

    state_e            state_q;
    logic [1:0]        ptr_q;
    logic [LENW-1:0]   rem_q;
    logic [3:0]        gnt_q;
    logic [1:0]        gid_q;
    logic              busy_q;
    logic              clr_q;
    logic              en_q;
    logic [3:0]        done_q;

    logic              win_found;
    logic [1:0]        win_idx;
    logic [1:0]        cand;
    logic [LENW-1:0]   win_len;

    // Walk offsets high to low so the smallest offset from ptr_q is the one that sticks.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_len = bus.len[win_idx*LENW +: LENW];
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            gnt_q   <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= '0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q <= StClr;
                        gid_q   <= win_idx;
                        rem_q   <= win_len;
                        gnt_q   <= 4'b0001 << win_idx;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                StClr, StRun: begin
                    if (!bus.req[gid_q]) begin
                        // Requester withdrew: release without done, but still move past it.
                        state_q <= StIdle;
                        ptr_q   <= gid_q + 2'd1;
                        gnt_q   <= '0;
                        gid_q   <= '0;
                        busy_q  <= 1'b0;
                        en_q    <= 1'b0;
                    end else if (state_q == StClr) begin
                        if (rem_q == '0) begin
                            state_q <= StDone;
                            done_q  <= 4'b0001 << gid_q;
                        end else begin
                            state_q <= StRun;
                            en_q    <= 1'b1;
                        end
                    end else begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == LENW'(1)) begin
                            state_q <= StDone;
                            en_q    <= 1'b0;
                            done_q  <= 4'b0001 << gid_q;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ptr_q   <= gid_q + 2'd1;
                    gnt_q   <= '0;
                    gid_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gid     = gid_q;
    assign bus.busy    = busy_q;
    assign bus.cnt_clr = clr_q;
    assign bus.cnt_en  = en_q;
    assign bus.done    = done_q;

endmodule
